// File: rtl/alu_pkg.sv
// Shared ALUOP encodings and iterative-ALU state encoding for iterative_alu
// and other arithmetic_controller consumers.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRA  = 4'b0001,
    ALU_SRL  = 4'b0010,
    ALU_MUL  = 4'b0011,
    ALU_ADD  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLT  = 4'b1011,
    ALU_SLTU = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bundle between the arithmetic controller (master) and
// iterative_alu (slave).
interface iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUOP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Equal;
  logic             Zero;

  modport master (
    output in_valid, ALUOP, A, B, out_ready,
    input  in_ready, out_valid, Result, Equal, Zero
  );

  modport slave (
    input  in_valid, ALUOP, A, B, out_ready,
    output in_ready, out_valid, Result, Equal, Zero
  );
endinterface

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations (pure combinational). Shift codes pass A through
// as the starting value for the iterative shifter; ITERATIVE_ALU_MUL_EN selects MUL.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_SLL, ALU_SRA, ALU_SRL: result = a;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ITERATIVE_ALU_MUL_EN
      // Multiply accumulates from zero in the iterative datapath.
      ALU_MUL:  result = '0;
`endif
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/iterative_alu.sv
// Iterative ALU: single-edge logic/arithmetic ops, one-bit-per-edge shifts, and
// an optional shift-add multiplier enabled by `define ITERATIVE_ALU_MUL_EN.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  iterative_alu_if.slave bus
);

  localparam int CNT_W = SHAMT_W + 1;

  alu_state_e       state;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] comb_res;
  logic             equal_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [SHAMT_W-1:0] shamt;
`ifdef ITERATIVE_ALU_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
`endif

  assign shamt = bus.B[SHAMT_W-1:0];

  alu_comb_ops #(.WIDTH(WIDTH)) u_ops (
    .op     (bus.ALUOP),
    .a      (bus.A),
    .b      (bus.B),
    .result (comb_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      cnt         <= '0;
      result_q    <= '0;
      equal_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
      mcand       <= '0;
      mplier      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q     <= bus.ALUOP;
            equal_q  <= (bus.A == bus.B);
            result_q <= comb_res;
            cnt      <= {1'b0, shamt};
            if (is_shift(bus.ALUOP) && (shamt != '0)) begin
              state      <= ST_BUSY;
              in_ready_q <= 1'b0;
            end
`ifdef ITERATIVE_ALU_MUL_EN
            else if (bus.ALUOP == ALU_MUL) begin
              cnt        <= CNT_W'(WIDTH);
              mcand      <= bus.A;
              mplier     <= bus.B;
              state      <= ST_BUSY;
              in_ready_q <= 1'b0;
            end
`endif
            else begin
              state       <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          // Result itself is the shift register, so intermediate values show
          // on Result while out_valid is low.
          case (op_q)
            ALU_SLL: result_q <= result_q << 1;
            ALU_SRL: result_q <= result_q >> 1;
            ALU_SRA: result_q <= {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: begin
`ifdef ITERATIVE_ALU_MUL_EN
              if (mplier[0]) result_q <= result_q + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
`endif
            end
          endcase
          if (cnt == CNT_W'(1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Equal     = equal_q;
  assign bus.Zero      = (result_q == '0);

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width (log2 WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port ALUOP  input  4  operation code from the arithmetic controller.
REQ-008 SHALL have ports A, B  input  WIDTH  operands; B[SHAMT_W-1:0] is the shift amount for shifts.
REQ-009 SHALL have port out_valid  output  1  Result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port Result  output  WIDTH  operation result.
REQ-012 SHALL have ports Equal, Zero  output  1 each  A==B captured at accept; Result==0.

Function
REQ-013 SHALL decode ALUOP: 0000 sll, 0001 sra, 0010 srl, 0101 add, 0110 sub, 0111 and, 1000 or, 1001 xor, 1011 slt (signed), 1100 sltu; every other code SHALL execute add.
REQ-014 SHALL implement states IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 Accept SHALL occur on the edge where in_valid&&in_ready; ALUOP, A, B and Equal are captured then; inputs are ignored outside IDLE.
REQ-016 Non-shift ops SHALL go IDLE->DONE on the accept edge (latency 1 edge).
REQ-017 Shifts SHALL load A and counter=shamt on accept; shamt==0 goes directly to DONE; otherwise BUSY shifts one bit per edge, decrements counter, enters DONE on the edge counter goes 1->0 (latency shamt+1 edges).
REQ-018 sra SHALL replicate the captured sign bit on each step; srl/sll SHALL fill zero.
REQ-019 slt/sltu SHALL produce Result = {WIDTH-1 zeros, compare bit}; add/sub wrap modulo 2^WIDTH.
REQ-020 In DONE, Result/Equal/Zero SHALL hold stable until out_valid&&out_ready, then go IDLE on that edge; no same-edge accept (one op in flight).
REQ-021 Result SHALL retain its last value in IDLE and BUSY intermediate values SHALL not be qualified by out_valid.

Reset
REQ-022 rst SHALL immediately force IDLE, counter 0, Result 0, Equal 0, out_valid 0, in_ready 1 (after release), aborting any op in BUSY or DONE without output.
REQ-023 First accept SHALL be possible on the first rising edge with rst low.

Configuration
REQ-024 With ITERATIVE_ALU_MUL_EN defined, ALUOP 0011 SHALL perform unsigned shift-add multiply, low WIDTH bits, one multiplier bit per BUSY edge, latency WIDTH+1 edges.
REQ-025 Without ITERATIVE_ALU_MUL_EN, ALUOP 0011 SHALL execute add (latency 1) and no multiply logic SHALL be present.

Structure
REQ-026 ALUOP encoding constants and the state encoding SHALL live in shared package alu_pkg, reused by arithmetic_controller consumers.
REQ-027 Single-cycle op evaluation SHALL be sub-module alu_comb_ops (pure combinational: ALUOP, A, B -> result); shift/multiply iteration stays in iterative_alu.

Verification
REQ-028 add: A=0x7FFFFFFF, B=1, ALUOP=0101 -> out_valid 1 edge after accept, Result=0x80000000, Zero=0.
REQ-029 sra: A=0x80000010, B=4, ALUOP=0001 -> in_ready low 5 edges, Result=0xF8000001; shamt 0 -> Result=A after 1 edge.
REQ-030 backpressure: sub A=5,B=5 with out_ready=0 for 10 edges -> Result=0, Zero=1, Equal=1 held stable, in_ready stays 0; new in_valid ignored until handshake.
REQ-031 reset mid-op: srl A=0xFFFFFFFF,B=31, assert rst after 3 BUSY edges -> out_valid never rises, Result=0, next op after release completes correctly.
REQ-032 slt vs sltu: A=0xFFFFFFFF, B=1 -> slt Result=1, sltu Result=0; ALUOP=1111 -> Result=A+B.
REQ-033 with ITERATIVE_ALU_MUL_EN: A=0x10001, B=0x10001, ALUOP=0011 -> Result=0x00020001 after 33 edges; without macro -> Result=0x00020002 after 1 edge.
